sd_clk_gen: RTL and testbench
=============================

SD_CLK_GEN -- requirements
Module: sd_clk_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 8, meaning divisor register width.
REQ-002 SHALL have parameter DIV_INIT, default 33, meaning reset divisor (27 MHz / 68 = ~397 kHz identification clock).
REQ-003 SHALL have parameter LOCK_CYCLES, default 4, meaning sd_clk rising edges after a divisor change before lock.
REQ-004 SHALL have port clkin, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port clk_en_i, input, 1, meaning run (1) / park low (0) request.
REQ-007 SHALL have port div_i, input, DIV_W, meaning requested divisor.
REQ-008 SHALL have port div_valid_i, input, 1, meaning div_i valid.
REQ-009 SHALL have port div_ready_o, output, 1, meaning divisor accepted when valid and ready.
REQ-010 SHALL have port sd_clk_o, output, 1, meaning registered divided clock.
REQ-011 SHALL have port rise_o, output, 1, meaning one-cycle strobe, high in the first cycle sd_clk_o reads 1.
REQ-012 SHALL have port fall_o, output, 1, meaning one-cycle strobe, high in the first cycle sd_clk_o reads 0.
REQ-013 SHALL have port locked_o, output, 1, meaning frequency stable and running.

Function
REQ-014 SHALL count cnt 0..div; at cnt==div cnt wraps to 0 and sd_clk_o toggles; each half-period = div+1 clkin cycles; div=0 gives period 2.
REQ-015 SHALL implement states RUN, PEND, SETTLE, STOP.
REQ-016 SHALL assert div_ready_o only in RUN or STOP with no pending divisor; handshake completes on valid&&ready in one cycle.
REQ-017 SHALL, on acceptance in RUN, latch div_i into a pending register, go PEND, drop locked_o next cycle.
REQ-018 SHALL, in PEND, apply the pending divisor only at the low-to-high toggle (cnt==div, sd_clk_o=0) so no half-period is shorter than min(old,new)+1; then go SETTLE.
REQ-019 SHALL, in SETTLE, count rise_o strobes; after LOCK_CYCLES go RUN and assert locked_o the cycle after the last counted rise.
REQ-020 SHALL, with clk_en_i=0, park at the point sd_clk_o would rise: hold sd_clk_o=0, cnt=div, go STOP, drop locked_o; never stop while high.
REQ-021 SHALL, on acceptance in STOP, load the divisor immediately (no PEND).
REQ-022 SHALL, when clk_en_i returns to 1 in STOP, restart with cnt=0, first rise after div+1 cycles, via SETTLE.
REQ-023 SHALL give clk_en_i=0 priority over a same-cycle pending application: divisor is still applied, then STOP.
REQ-024 SHALL ignore div_valid_i while div_ready_o=0 (no queueing).

Reset
REQ-025 SHALL on reset set sd_clk_o=0, cnt=0, div=DIV_INIT, rise_o=fall_o=0, locked_o=0, div_ready_o=0, state SETTLE (or STOP if clk_en_i=0); reset mid-PEND discards the pending divisor.

Configuration
REQ-026 SHALL, with SD_CLK_GEN_LOCK_EN defined, implement SETTLE counting per REQ-019.
REQ-027 SHALL, without SD_CLK_GEN_LOCK_EN, omit the settle counter: SETTLE lasts zero cycles and locked_o asserts the cycle after the divisor is applied or after restart.

Structure
REQ-028 SHALL place the state enum and default DIV_INIT/LOCK_CYCLES constants in the shared package sd_pkg.
REQ-029 SHALL be a single module; no sub-module.

Verification
REQ-030 SHALL check reset release with DIV_INIT=33, clk_en_i=1 -> sd_clk_o period 68 cycles, 34 high/34 low; locked_o after 4th rise.
REQ-031 SHALL check load div_i=0 mid-high phase -> old half completes, next high half 1 cycle, period 2, locked_o after 4 rises.
REQ-032 SHALL check clk_en_i=0 during high phase -> sd_clk_o finishes high, parks low, locked_o=0, no rise_o while stopped.
REQ-033 SHALL check div_valid_i held during PEND -> div_ready_o=0, second value not applied.
REQ-034 SHALL check reset asserted in PEND -> sd_clk_o=0 next cycle, divisor back to 33.
REQ-035 SHALL check, without SD_CLK_GEN_LOCK_EN, divisor 33->1 -> locked_o high one cycle after application.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared types and default constants for the SD card clock generator.
package sd_pkg;

    localparam int SD_DIV_W       = 8;
    localparam int SD_DIV_INIT    = 33;
    localparam int SD_LOCK_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PEND   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_STOP   = 2'd3
    } sd_state_e;

    // A new divisor can only be taken while running steadily or parked.
    function automatic logic sd_is_ready(input sd_state_e st);
        return (st == ST_RUN) || (st == ST_STOP);
    endfunction

endpackage

// File: rtl/sd_clk_gen_if.sv
// Divisor handshake and clock outputs of sd_clk_gen, grouped for benches and
// integration wrappers.
interface sd_clk_gen_if
    import sd_pkg::*;
#(
    parameter int DIV_W = SD_DIV_W
);
    logic             clk_en_i;
    logic [DIV_W-1:0] div_i;
    logic             div_valid_i;
    logic             div_ready_o;
    logic             sd_clk_o;
    logic             rise_o;
    logic             fall_o;
    logic             locked_o;

    modport master (
        output clk_en_i, div_i, div_valid_i,
        input  div_ready_o, sd_clk_o, rise_o, fall_o, locked_o
    );

    modport slave (
        input  clk_en_i, div_i, div_valid_i,
        output div_ready_o, sd_clk_o, rise_o, fall_o, locked_o
    );
endinterface

// File: rtl/sd_clk_gen.sv
// Glitch-free programmable SD clock divider with safe divisor change and park.
// Optional macro SD_CLK_GEN_LOCK_EN enables the post-change settle counter.
module sd_clk_gen
    import sd_pkg::*;
#(
    parameter int DIV_W       = SD_DIV_W,
    parameter int DIV_INIT    = SD_DIV_INIT,
    parameter int LOCK_CYCLES = SD_LOCK_CYCLES
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             clk_en_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_valid_i,
    output logic             div_ready_o,
    output logic             sd_clk_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             locked_o
);

    sd_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             sd_clk_q, sd_clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             locked_q, locked_d;
    logic             ready_q, ready_d;
    logic             accept_s;
    logic             tick_s;
    logic             rise_pt_s;

`ifdef SD_CLK_GEN_LOCK_EN
    localparam int SCNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(LOCK_CYCLES - 1);
    logic [SCNT_W-1:0] scnt_q, scnt_d;
`endif

    assign accept_s  = div_valid_i && ready_q;
    assign tick_s    = (cnt_q == div_q);
    assign rise_pt_s = tick_s && !sd_clk_q;

    // Next-state, divider and strobe logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        pend_d   = pend_q;
        sd_clk_d = sd_clk_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        locked_d = locked_q;
`ifdef SD_CLK_GEN_LOCK_EN
        scnt_d   = scnt_q;
`endif
        case (state_q)
            ST_RUN, ST_PEND, ST_SETTLE: begin
                if (tick_s) begin
                    cnt_d    = {DIV_W{1'b0}};
                    sd_clk_d = ~sd_clk_q;
                    rise_d   = ~sd_clk_q;
                    fall_d   = sd_clk_q;
                end else begin
                    cnt_d    = cnt_q + DIV_W'(1);
                end
                // Parking replaces the rising toggle; a pending divisor still lands.
                if (rise_pt_s && !clk_en_i) begin
                    sd_clk_d = 1'b0;
                    rise_d   = 1'b0;
                    locked_d = 1'b0;
                    state_d  = ST_STOP;
                    if (state_q == ST_PEND) begin
                        div_d = pend_q;
                        cnt_d = pend_q;
                    end else if (accept_s) begin
                        div_d = div_i;
                        cnt_d = div_i;
                    end else begin
                        cnt_d = div_q;
                    end
                end else begin
                    case (state_q)
                        ST_RUN: begin
                            if (accept_s) begin
                                pend_d   = div_i;
                                locked_d = 1'b0;
                                state_d  = ST_PEND;
                            end else begin
                                state_d  = ST_RUN;
                            end
                        end
                        ST_PEND: begin
                            if (rise_pt_s) begin
                                div_d    = pend_q;
`ifdef SD_CLK_GEN_LOCK_EN
                                scnt_d   = {SCNT_W{1'b0}};
                                locked_d = 1'b0;
                                state_d  = ST_SETTLE;
`else
                                locked_d = 1'b1;
                                state_d  = ST_RUN;
`endif
                            end else begin
                                state_d  = ST_PEND;
                            end
                        end
                        ST_SETTLE: begin
`ifdef SD_CLK_GEN_LOCK_EN
                            if (rise_q) begin
                                if (scnt_q == SCNT_LAST) begin
                                    locked_d = 1'b1;
                                    state_d  = ST_RUN;
                                end else begin
                                    scnt_d   = scnt_q + SCNT_W'(1);
                                end
                            end else begin
                                state_d  = ST_SETTLE;
                            end
`else
                            locked_d = 1'b1;
                            state_d  = ST_RUN;
`endif
                        end
                        default: begin
                            state_d = state_q;
                        end
                    endcase
                end
            end
            ST_STOP: begin
                sd_clk_d = 1'b0;
                if (accept_s) begin
                    div_d = div_i;
                    cnt_d = div_i;
                end else begin
                    div_d = div_q;
                end
                if (clk_en_i) begin
                    cnt_d    = {DIV_W{1'b0}};
`ifdef SD_CLK_GEN_LOCK_EN
                    scnt_d   = {SCNT_W{1'b0}};
                    locked_d = 1'b0;
                    state_d  = ST_SETTLE;
`else
                    locked_d = 1'b1;
                    state_d  = ST_RUN;
`endif
                end else begin
                    state_d  = ST_STOP;
                end
            end
            default: begin
                sd_clk_d = 1'b0;
                locked_d = 1'b0;
                cnt_d    = div_q;
                state_d  = ST_STOP;
            end
        endcase
        ready_d = sd_is_ready(state_d);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q  <= clk_en_i ? ST_SETTLE : ST_STOP;
            cnt_q    <= {DIV_W{1'b0}};
            div_q    <= DIV_W'(DIV_INIT);
            pend_q   <= {DIV_W{1'b0}};
            sd_clk_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            locked_q <= 1'b0;
            ready_q  <= 1'b0;
`ifdef SD_CLK_GEN_LOCK_EN
            scnt_q   <= {SCNT_W{1'b0}};
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            pend_q   <= pend_d;
            sd_clk_q <= sd_clk_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            locked_q <= locked_d;
            ready_q  <= ready_d;
`ifdef SD_CLK_GEN_LOCK_EN
            scnt_q   <= scnt_d;
`endif
        end
    end

    assign div_ready_o = ready_q;
    assign sd_clk_o    = sd_clk_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    assign locked_o    = locked_q;

endmodule

// File: tb/tb_sd_clk_gen.sv
// Randomized bench for sd_clk_gen against an edge-time reference model.
module tb_sd_clk_gen;

`ifdef SD_CLK_GEN_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif
    localparam int INIT_DIV = 33;
    localparam int LOCK_N   = 4;

    logic clkin = 1'b0;
    logic reset;

    always #5 clkin = ~clkin;

    sd_clk_gen_if bus ();

    sd_clk_gen dut (
        .clkin       (clkin),
        .reset       (reset),
        .clk_en_i    (bus.clk_en_i),
        .div_i       (bus.div_i),
        .div_valid_i (bus.div_valid_i),
        .div_ready_o (bus.div_ready_o),
        .sd_clk_o    (bus.sd_clk_o),
        .rise_o      (bus.rise_o),
        .fall_o      (bus.fall_o),
        .locked_o    (bus.locked_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: absolute edge times instead of a counter.
    int t;
    int m_next;
    int m_div;
    int m_pdiv;
    int m_rises;
    bit m_lvl, m_rise, m_fall, m_locked, m_ready, m_stop, m_pend, m_settle;

    int run_len;
    bit last_lvl;
    int runs[$];
    int n_rise;
    bit r_en, r_v;
    logic [7:0] r_d;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] dut_outs();
        return {bus.sd_clk_o, bus.rise_o, bus.fall_o, bus.locked_o, bus.div_ready_o};
    endfunction

    task automatic model_reset(input bit en);
        t++;
        m_lvl = 0; m_rise = 0; m_fall = 0; m_locked = 0; m_ready = 0;
        m_pend = 0; m_rises = 0; m_div = INIT_DIV;
        m_stop = !en; m_settle = en;
        m_next = t + m_div + 1;
    endtask

    task automatic start_settle();
        m_rises = 0;
        if (LOCK_EN) begin
            m_settle = 1; m_locked = 0;
        end else begin
            m_settle = 0; m_locked = 1;
        end
    endtask

    task automatic model_step(input bit en, input bit v, input int d);
        bit acc;
        bit prev_rise;
        acc = v && m_ready;
        prev_rise = m_rise;
        t++;
        m_rise = 0; m_fall = 0;
        if (m_stop) begin
            if (acc) m_div = d;
            if (en) begin
                m_stop = 0;
                m_next = t + m_div + 1;
                start_settle();
            end
        end else begin
            if (m_settle) begin
                if (!LOCK_EN) begin
                    m_settle = 0; m_locked = 1;
                end else if (prev_rise) begin
                    m_rises++;
                    if (m_rises == LOCK_N) begin
                        m_settle = 0; m_locked = 1;
                    end
                end
            end
            if (t == m_next && m_lvl) begin
                m_lvl = 0; m_fall = 1;
                m_next = t + m_div + 1;
            end else if (t == m_next) begin
                bit applied;
                applied = 0;
                if (m_pend) begin
                    m_div = m_pdiv; m_pend = 0; applied = 1;
                end
                if (!en) begin
                    if (acc) m_div = d;
                    acc = 0;
                    m_stop = 1; m_locked = 0; m_settle = 0;
                end else begin
                    m_lvl = 1; m_rise = 1;
                    m_next = t + m_div + 1;
                    if (applied) start_settle();
                end
            end
            if (acc) begin
                m_pend = 1; m_pdiv = d; m_locked = 0;
            end
        end
        m_ready = m_stop || (!m_pend && !m_settle);
    endtask

    task automatic clear_runs();
        runs.delete();
        run_len = 0;
        last_lvl = bus.sd_clk_o;
    endtask

    task automatic step(input bit en, input bit v, input logic [7:0] d);
        bus.clk_en_i = en; bus.div_valid_i = v; bus.div_i = d;
        @(posedge clkin);
        model_step(en, v, int'(d));
        @(negedge clkin);
        check_eq("outs", {27'd0, dut_outs()}, {27'd0, m_lvl, m_rise, m_fall, m_locked, m_ready});
        if (bus.sd_clk_o === last_lvl) begin
            run_len++;
        end else begin
            runs.push_back(run_len);
            run_len = 1;
            last_lvl = bus.sd_clk_o;
        end
    endtask

    task automatic do_reset(input bit en, input int n);
        for (int i = 0; i < n; i++) begin
            reset = 1'b1;
            bus.clk_en_i = en; bus.div_valid_i = 1'b0; bus.div_i = 8'd0;
            @(posedge clkin);
            model_reset(en);
            @(negedge clkin);
            check_eq("rst_outs", {27'd0, dut_outs()}, 32'd0);
        end
        reset = 1'b0;
        clear_runs();
    endtask

    task automatic wait_lvl(input bit lvl);
        for (int i = 0; i < 200 && bus.sd_clk_o !== lvl; i++) step(1'b1, 1'b0, 8'd0);
    endtask

    function automatic int run_at(input int idx);
        return (runs.size() > idx) ? runs[idx] : -1;
    endfunction

    initial begin
        reset = 1'b1;
        bus.clk_en_i = 1'b1; bus.div_valid_i = 1'b0; bus.div_i = 8'd0;
        t = 0;
        @(negedge clkin);

        // Reset release: 34 high / 34 low, lock by the 4th rise.
        do_reset(1'b1, 2);
        for (int i = 0; i < 320; i++) step(1'b1, 1'b0, 8'd0);
        check_eq("init_high", run_at(1), 34);
        check_eq("init_low", run_at(2), 34);
        check_eq("init_lock", {31'd0, bus.locked_o}, 32'd1);

        // Divisor 0 loaded mid-high; a second value held during PEND is ignored.
        wait_lvl(1'b1);
        step(1'b1, 1'b1, 8'd0);
        for (int i = 0; i < 200 && m_pend; i++) begin
            check_eq("pend_ready", {31'd0, bus.div_ready_o}, 32'd0);
            step(1'b1, 1'b1, 8'd9);
        end
        check_eq("pend_done", {31'd0, m_pend}, 32'd0);
        clear_runs();
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 8'd0);
        check_eq("fast_half", run_at(int'(runs.size()) - 1), 1);

        // Stop requested while high: finish high, park low, no rises.
        wait_lvl(1'b1);
        n_rise = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'b0, 8'd0);
            if (bus.rise_o === 1'b1) n_rise++;
        end
        check_eq("stop_rises", n_rise, 0);
        check_eq("stop_clk", {31'd0, bus.sd_clk_o}, 32'd0);
        check_eq("stop_lock", {31'd0, bus.locked_o}, 32'd0);
        check_eq("stop_ready", {31'd0, bus.div_ready_o}, 32'd1);

        // Load while stopped, restart.
        step(1'b0, 1'b1, 8'd3);
        for (int i = 0; i < 80; i++) step(1'b1, 1'b0, 8'd0);

        // Reset while a divisor is pending.
        for (int i = 0; i < 400 && !m_ready; i++) step(1'b1, 1'b0, 8'd0);
        wait_lvl(1'b1);
        step(1'b1, 1'b1, 8'd7);
        step(1'b1, 1'b0, 8'd0);
        check_eq("in_pend", {31'd0, m_pend}, 32'd1);
        do_reset(1'b1, 1);
        for (int i = 0; i < 150; i++) step(1'b1, 1'b0, 8'd0);
        check_eq("rst_div_high", run_at(1), 34);

        // 33 -> 1: lock timing around the application edge.
        for (int i = 0; i < 400 && !m_ready; i++) step(1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, 8'd1);
        for (int i = 0; i < 200 && m_pend; i++) step(1'b1, 1'b0, 8'd0);
        check_eq("apply_seen", {31'd0, m_pend}, 32'd0);
        check_eq("apply_rise", {31'd0, bus.rise_o}, 32'd1);
        check_eq("apply_lock", {31'd0, bus.locked_o}, {31'd0, !LOCK_EN});
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 8'd0);

        // Random traffic.
        r_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) r_en = !r_en;
            if ($urandom_range(0, 499) == 0) begin
                do_reset(r_en, 1);
            end else begin
                r_v = ($urandom_range(0, 19) == 0);
                r_d = ($urandom_range(0, 7) == 0) ? 8'd40 : 8'($urandom_range(0, 6));
                step(r_en, r_v, r_d);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
